// File: rtl/simon_pkg.sv
// Shared widths, pipeline latency and key-change state encoding for the
// Simon32/64 streaming controller.
package simon_pkg;

  localparam int BLOCK_W      = 32;
  localparam int KEY_W        = 64;
  localparam int PIPE_LATENCY = 33;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD,
    SETTLE
  } key_state_t;

endpackage

// File: rtl/simon_stream_ctrl_if.sv
// Plaintext in, ciphertext out and key-change request/status of the
// streaming controller, bundled as one bus.
interface simon_stream_ctrl_if;
  import simon_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [BLOCK_W-1:0] s_data;
  logic               key_req;
  logic [KEY_W-1:0]   key_in;
  logic               key_busy;
  logic               m_valid;
  logic               m_ready;
  logic [BLOCK_W-1:0] m_data;

  modport master (
    output s_valid, s_data, key_req, key_in, m_ready,
    input  s_ready, key_busy, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, key_req, key_in, m_ready,
    output s_ready, key_busy, m_valid, m_data
  );

endinterface

// File: rtl/simon_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is visible on rdata
// whenever the FIFO is not empty.
module simon_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/simon_stream_ctrl.sv
// Valid tracking, credit-based input throttling, ciphertext buffering and key
// change sequencing around a stall-free Simon32/64 pipeline.
module simon_stream_ctrl
  import simon_pkg::*;
#(
  parameter int LATENCY    = PIPE_LATENCY,
  parameter int DEPTH      = 64,
  parameter int KEY_SETTLE = 32
) (
  input  logic                clk,
  input  logic                rst,
  simon_stream_ctrl_if.slave  bus,
  output logic [BLOCK_W-1:0]  pt_out,
  output logic [KEY_W-1:0]    key_out,
  input  logic [BLOCK_W-1:0]  ct_in
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(KEY_SETTLE + 1);

  key_state_t       state_q;
  logic [KEY_W-1:0] key_lat_q;
  logic [KEY_W-1:0] key_out_q;
  logic [SW-1:0]    settle_q;
  logic             key_busy_q;
  logic [LATENCY:0] dl_q;
  logic [LATENCY:0] dl_d;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    inflight_d;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             credit_ok;
  logic             launch;
  logic             ct_wr;
  logic             pop;

  // Every launched word holds a credit until it lands in the FIFO, so the
  // buffer always has room for everything still travelling the pipeline.
  assign credit_ok   = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
  assign bus.s_ready = ~rst & (state_q == IDLE) & credit_ok;
  assign launch      = bus.s_valid & bus.s_ready;
  assign ct_wr       = dl_q[LATENCY];
  assign pop         = bus.m_valid & bus.m_ready;

  assign dl_d       = {dl_q[LATENCY-1:0], launch};
  assign inflight_d = inflight_q + CW'(launch) - CW'(ct_wr);

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q       <= '0;
      inflight_q <= '0;
    end else begin
      dl_q       <= dl_d;
      inflight_q <= inflight_d;
    end
  end

  simon_sync_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ct_wr),
    .pop   (pop),
    .wdata (ct_in),
    .rdata (bus.m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // New keytext is only driven once the pipeline is empty, then held off
  // input long enough for the round-key schedule to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      key_lat_q  <= '0;
      key_out_q  <= '0;
      settle_q   <= '0;
      key_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.key_req) begin
            key_lat_q  <= bus.key_in;
            key_busy_q <= 1'b1;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_q == '0) state_q <= LOAD;
        end
        LOAD: begin
          key_out_q <= key_lat_q;
          settle_q  <= SW'(KEY_SETTLE - 1);
          state_q   <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            key_busy_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_valid  = ~fifo_empty;
  assign bus.key_busy = key_busy_q;
  assign pt_out       = bus.s_data;
  assign key_out      = key_out_q;

  a_credit_holds: assert property (@(posedge clk) disable iff (rst) !(ct_wr && fifo_full));

endmodule

// File: tb/tb_simon_stream_ctrl.sv
// Directed bench for simon_stream_ctrl with a behavioural 33-edge Simon32/64
// pipeline and an in-order ciphertext scoreboard.
module tb_simon_stream_ctrl;
  import simon_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pt_out;
  logic [31:0] ct_in;
  logic [63:0] key_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simon_stream_ctrl_if bus();

  simon_stream_ctrl #(
    .LATENCY    (LAT),
    .DEPTH      (DEPTH),
    .KEY_SETTLE (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pt_out  (pt_out),
    .key_out (key_out),
    .ct_in   (ct_in)
  );

  // Reference Simon32/64 encryption (n=16, m=4, 32 rounds, sequence z0).
  function automatic logic [31:0] simonEnc(input logic [31:0] pt, input logic [63:0] key);
    logic [15:0] k [0:31];
    logic [15:0] x, y, tmp;
    logic [61:0] z;
    z = 62'h19C3522FB386A45F;
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int i = 4; i < 32; i++) begin
      tmp  = {k[i-1][2:0], k[i-1][15:3]};
      tmp  = tmp ^ k[i-3];
      tmp  = tmp ^ {tmp[0], tmp[15:1]};
      k[i] = ~k[i-4] ^ tmp ^ {15'b0, z[i-4]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x   = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // Stand-in for the real pipeline: sample at edge t, ciphertext register at t+33.
  logic [31:0] pipe [0:LAT];
  always @(posedge clk) begin
    pipe[0] <= simonEnc(pt_out, key_out);
    for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ct_in = pipe[LAT];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected ciphertexts use the key the bench believes is loaded.
  logic [31:0] expQ [$];
  logic [63:0] tbKey;
  int          popCount = 0;

  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        popCount++;
        if (expQ.size() == 0) checkOutput("queue_has_entry", 64'(expQ.size()), 64'd1);
        else                  checkOutput("m_data", {32'b0, bus.m_data}, {32'b0, expQ.pop_front()});
      end
      if (bus.s_valid && bus.s_ready) expQ.push_back(simonEnc(bus.s_data, tbKey));
    end
  end

  int   mvHigh = 0;
  int   mvRise = 0;
  logic mvPrev = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.m_valid) mvHigh++;
    if (bus.m_valid && !mvPrev) mvRise++;
    mvPrev = bus.m_valid;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic kr,
                               input logic [63:0] k, input logic mr);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.key_req = kr;
    bus.key_in  = k;
    bus.m_ready = mr;
  endtask

  task automatic loadKey(input logic [63:0] k);
    int n;
    applyStimulus(1'b0, 32'h0, 1'b1, k, 1'b1);
    tick();
    bus.key_req = 1'b0;
    n = 0;
    while (bus.key_busy && n < 200) begin
      tick();
      n++;
    end
    checkOutput("key_load_done", {63'b0, bus.key_busy}, 64'd0);
    checkOutput("key_out_loaded", key_out, k);
    tbKey = k;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, drops, acc, popBase, rel, keyChg, keyChgRel, readyRel, busyFallRel, stale;
    logic        busy1, busyAtReady;
    logic [63:0] prevKey;

    rst   = 1'b1;
    tbKey = 64'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    tick();
    checkOutput("reset_s_ready",  {63'b0, bus.s_ready},  64'd0);
    checkOutput("reset_m_valid",  {63'b0, bus.m_valid},  64'd0);
    checkOutput("reset_key_busy", {63'b0, bus.key_busy}, 64'd0);
    checkOutput("reset_key_out",  key_out,               64'd0);
    rst = 1'b0;
    tick();
    checkOutput("ready_after_reset", {63'b0, bus.s_ready}, 64'd1);

    // Known-answer vector and accept-to-m_valid latency.
    loadKey(64'h1918_1110_0908_0100);
    applyStimulus(1'b1, 32'h6565_6877, 1'b0, 64'h0, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    lat = 0;
    while (!bus.m_valid && lat < 60) begin
      tick();
      lat++;
    end
    checkOutput("kat_latency", 64'(lat), 64'd34);
    checkOutput("kat_data", {32'b0, bus.m_data}, 64'h0000_0000_c69b_e9bb);
    tick();
    tick();

    // Back-to-back stream with a free-running consumer.
    mvHigh = 0;
    mvRise = 0;
    mvPrev = bus.m_valid;
    drops  = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 64'h0, 1'b1);
      if (!bus.s_ready) drops++;
      tick();
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    checkOutput("burst_ready_drops", 64'(drops), 64'd0);
    checkOutput("burst_results", 64'(mvHigh), 64'd200);
    checkOutput("burst_contiguous", 64'(mvRise), 64'd1);
    checkOutput("burst_drained", 64'(expQ.size()), 64'd0);

    // Stalled consumer: credits must cap acceptance at DEPTH.
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 64'h0, 1'b0);
      if (bus.s_ready) acc++;
      tick();
    end
    checkOutput("bp_accepted", 64'(acc), 64'(DEPTH));
    checkOutput("bp_s_ready", {63'b0, bus.s_ready}, 64'd0);
    checkOutput("bp_m_valid", {63'b0, bus.m_valid}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    popBase = popCount;
    for (int i = 0; i < 80; i++) tick();
    checkOutput("bp_popped", 64'(popCount - popBase), 64'(DEPTH));
    checkOutput("bp_ready_back", {63'b0, bus.s_ready}, 64'd1);
    checkOutput("bp_drained", 64'(expQ.size()), 64'd0);

    // Key change with ten words in flight.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 64'h0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 64'h0123_4567_89ab_cdef, 1'b1);
    rel = 0; keyChg = 0; keyChgRel = -1; readyRel = -1;
    busy1 = 1'b0; busyAtReady = 1'b1;
    prevKey = key_out;
    while (rel < 200 && readyRel < 0) begin
      tick();
      rel++;
      bus.key_req = 1'b0;
      if (rel == 1) busy1 = bus.key_busy;
      if (key_out !== prevKey) begin
        keyChg++;
        keyChgRel = rel;
        prevKey   = key_out;
      end
      if (bus.s_ready) begin
        readyRel    = rel;
        busyAtReady = bus.key_busy;
      end
    end
    checkOutput("kc_busy_start", {63'b0, busy1}, 64'd1);
    checkOutput("kc_key_change_cycle", 64'(keyChgRel), 64'd36);
    checkOutput("kc_ready_cycle", 64'(readyRel), 64'd68);
    checkOutput("kc_key_changes", 64'(keyChg), 64'd1);
    checkOutput("kc_busy_at_ready", {63'b0, busyAtReady}, 64'd0);
    checkOutput("kc_key_out", key_out, 64'h0123_4567_89ab_cdef);
    tbKey = 64'h0123_4567_89ab_cdef;
    applyStimulus(1'b1, $urandom, 1'b0, 64'h0, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checkOutput("kc_drained", 64'(expQ.size()), 64'd0);

    // Second key request during SETTLE must be ignored.
    applyStimulus(1'b0, 32'h0, 1'b1, 64'hfedc_ba98_7654_3210, 1'b1);
    rel = 0; keyChg = 0; busyFallRel = -1;
    prevKey = key_out;
    while (rel < 200 && busyFallRel < 0) begin
      tick();
      rel++;
      bus.key_req = (rel == 9);
      if (rel == 9) bus.key_in = 64'h1111_2222_3333_4444;
      if (key_out !== prevKey) begin
        keyChg++;
        prevKey = key_out;
      end
      if (!bus.key_busy) busyFallRel = rel;
    end
    bus.key_req = 1'b0;
    checkOutput("dbl_busy_fall", 64'(busyFallRel), 64'd35);
    checkOutput("dbl_key_changes", 64'(keyChg), 64'd1);
    checkOutput("dbl_key_out", key_out, 64'hfedc_ba98_7654_3210);
    tbKey = 64'hfedc_ba98_7654_3210;

    // Reset with words buffered and in flight.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 64'h0, 1'b0);
      tick();
    end
    checkOutput("pre_reset_m_valid", {63'b0, bus.m_valid}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    tbKey = 64'h0;
    checkOutput("post_reset_m_valid", {63'b0, bus.m_valid}, 64'd0);
    checkOutput("post_reset_key_out", key_out, 64'd0);
    popBase = popCount;
    stale   = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.m_valid) stale++;
    end
    checkOutput("no_stale_words", 64'(stale), 64'd0);
    applyStimulus(1'b1, 32'h6565_6877, 1'b0, 64'h0, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checkOutput("post_reset_results", 64'(popCount - popBase), 64'd1);
    checkOutput("post_reset_drained", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
